// File: rtl/pq_traffic_gen.sv
// Self-running stimulus generator for the priority queue: issues LFSR-keyed enq/deq
// operations only when legal, tracks its own occupancy and flags status mismatches.
module pq_traffic_gen #(
  parameter int          CAPACITY = 8,
  parameter logic [15:0] SEED     = 16'hACE1
) (
  input  logic                               clk,
  input  logic                               rst,
  input  logic                               start,
  input  logic                               stop,
  input  logic [1:0]                         mode,
  input  logic                               busy,
  input  logic                               full,
  input  logic                               empty,
  output logic                               enq,
  output logic                               deq,
  output logic [15:0]                        kvi,
  output logic                               running,
  output logic                               done,
  output logic [$clog2(CAPACITY+1)-1:0]      occ,
  output logic [15:0]                        enq_count,
  output logic [15:0]                        deq_count,
  output logic                               err
);

  localparam int            OW    = $clog2(CAPACITY + 1);
  localparam logic [OW-1:0] CAP_V = OW'(CAPACITY);

  typedef enum logic [1:0] {IDLE, ISSUE, HOLD, WAIT} state_e;

  state_e        state_q;
  logic          mix_q, drain_q, stop_pend_q;
  logic          enq_q, deq_q, done_q, err_q;
  logic [15:0]   lfsr_q, kvi_q, enq_cnt_q, deq_cnt_q;
  logic [OW-1:0] occ_q;

  logic          occ_full, occ_empty, evaluate;
  logic          mix_enq, mix_deq, issue_enq, issue_deq;
  logic [15:0]   lfsr_d;

  assign occ_full  = (occ_q == CAP_V);
  assign occ_empty = (occ_q == '0);
  assign evaluate  = (state_q == ISSUE) && !busy;
  assign lfsr_d    = {lfsr_q[14:0], lfsr_q[15] ^ lfsr_q[13] ^ lfsr_q[12] ^ lfsr_q[10]};

  // NOTE: every signal driven in always_comb gets a default first so no latch is inferred.
  always_comb begin
    mix_enq = 1'b0;
    mix_deq = 1'b0;
    unique case (lfsr_q[1:0])
      2'b00, 2'b01: if (occ_full) mix_deq = 1'b1; else mix_enq = 1'b1;
      2'b10:        if (occ_empty) mix_enq = 1'b1; else mix_deq = 1'b1;
      2'b11: begin
        mix_enq = !occ_full;
        mix_deq = !occ_empty;
      end
    endcase
  end

  always_comb begin
    issue_enq = 1'b0;
    issue_deq = 1'b0;
    if (evaluate && !stop_pend_q) begin
      if (mix_q) begin
        issue_enq = mix_enq;
        issue_deq = mix_deq;
      end else if (!drain_q) begin
        issue_enq = !occ_full;
      end else begin
        issue_deq = !occ_empty;
      end
    end
  end

  // NOTE: sequential state uses non-blocking assignments so all registers update together.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q     <= IDLE;
      mix_q       <= 1'b0;
      drain_q     <= 1'b0;
      stop_pend_q <= 1'b0;
      enq_q       <= 1'b0;
      deq_q       <= 1'b0;
      done_q      <= 1'b0;
      err_q       <= 1'b0;
      lfsr_q      <= SEED;
      kvi_q       <= '0;
      enq_cnt_q   <= '0;
      deq_cnt_q   <= '0;
      occ_q       <= '0;
    end else begin
      enq_q  <= 1'b0;
      deq_q  <= 1'b0;
      done_q <= 1'b0;
      if (stop && state_q != IDLE) stop_pend_q <= 1'b1;

      if (issue_enq || issue_deq) begin
        enq_q  <= issue_enq;
        deq_q  <= issue_deq;
        lfsr_q <= lfsr_d;
        if (issue_enq) begin
          kvi_q     <= lfsr_q;
          enq_cnt_q <= enq_cnt_q + 16'd1;
        end
        if (issue_deq) deq_cnt_q <= deq_cnt_q + 16'd1;
        if (issue_enq && !issue_deq)      occ_q <= occ_q + OW'(1);
        else if (issue_deq && !issue_enq) occ_q <= occ_q - OW'(1);
      end

      unique case (state_q)
        IDLE: begin
          stop_pend_q <= 1'b0;
          if (start) begin
            lfsr_q    <= SEED;
            occ_q     <= '0;
            enq_cnt_q <= '0;
            deq_cnt_q <= '0;
            err_q     <= 1'b0;
            mix_q     <= (mode == 2'b01);
            drain_q   <= 1'b0;
            state_q   <= ISSUE;
          end
        end
        ISSUE: if (!busy) begin
          if ((full != occ_full) || (empty != occ_empty)) err_q <= 1'b1;
          if (issue_enq || issue_deq) begin
            state_q <= HOLD;
          end else if (stop_pend_q || drain_q) begin
            // MIX always has a legal op, so no-issue here means stop or an empty drain.
            state_q <= IDLE;
            done_q  <= 1'b1;
          end else begin
            drain_q <= 1'b1;
          end
        end
        HOLD: state_q <= WAIT;
        WAIT: if (!busy) state_q <= ISSUE;
        default: state_q <= IDLE;
      endcase
    end
  end

  assign enq       = enq_q;
  assign deq       = deq_q;
  assign kvi       = kvi_q;
  assign running   = (state_q != IDLE);
  assign done      = done_q;
  assign occ       = occ_q;
  assign enq_count = enq_cnt_q;
  assign deq_count = deq_cnt_q;
  assign err       = err_q;

endmodule

// File: tb/tb_pq_traffic_gen.sv
// Directed bench for pq_traffic_gen: a small queue model supplies busy/full/empty and a
// negedge monitor gathers strobe statistics that each scenario task then compares.
module tb_pq_traffic_gen;

  localparam int CAP = 8;

  logic        clk = 1'b0;
  logic        rst = 1'b1, start = 1'b0, stop = 1'b0;
  logic [1:0]  mode = 2'b00;
  logic        busy, full, empty;
  logic        enq, deq, running, done, err;
  logic [15:0] kvi, enq_count, deq_count;
  logic [3:0]  occ;

  int errors = 0, checks = 0;

  // Queue model and monitor state
  int  qcount = 0, busy_left = 0, cyc = 0;
  bit  busy_mode = 1'b0, force_full = 1'b0, stop_sent = 1'b0, done_seen = 1'b0;
  int  n_enq, n_deq, n_both, n_strobe, n_done;
  int  last_strobe, min_gap, first_deq, last_enq;
  int  viol_busy, viol_illegal, viol_occ, viol_ident, after_done, after_stop;
  logic [15:0] kv_log[$];

  pq_traffic_gen #(.CAPACITY(CAP), .SEED(16'hACE1)) dut (
    .clk(clk), .rst(rst), .start(start), .stop(stop), .mode(mode),
    .busy(busy), .full(full), .empty(empty),
    .enq(enq), .deq(deq), .kvi(kvi), .running(running), .done(done), .occ(occ),
    .enq_count(enq_count), .deq_count(deq_count), .err(err)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  assign busy  = (busy_left > 0);
  assign full  = (qcount == CAP) || (force_full && qcount == 3);
  assign empty = (qcount == 0);

  function automatic logic [15:0] lfsr_step(input logic [15:0] l);
    return {l[14:0], l[15] ^ l[13] ^ l[12] ^ l[10]};
  endfunction

  always @(negedge clk) begin
    if (!rst) begin
      if (enq || deq) begin
        if (busy) viol_busy++;
        if (enq && !deq && qcount >= CAP) viol_illegal++;
        if (deq && !enq && qcount <= 0) viol_illegal++;
        if (enq && deq && (qcount == 0 || qcount == CAP)) viol_illegal++;
        if (done_seen) after_done++;
        if (stop_sent) after_stop++;
        if (enq) begin kv_log.push_back(kvi); last_enq = n_strobe; n_enq++; end
        if (deq) begin if (first_deq < 0) first_deq = n_strobe; n_deq++; end
        if (enq && deq) n_both++;
        if (last_strobe >= 0 && (cyc - last_strobe) < min_gap) min_gap = cyc - last_strobe;
        last_strobe = cyc;
        n_strobe++;
        if (enq && !deq) qcount++;
        if (deq && !enq) qcount--;
        if (busy_mode) busy_left = 5;
      end else if (busy_left > 0) begin
        busy_left--;
      end
      if (occ > 4'(CAP)) viol_occ++;
      if (running && {12'd0, occ} !== 16'(enq_count - deq_count)) viol_ident++;
      if (done) begin n_done++; done_seen = 1'b1; end
    end
  end

  task automatic step();
    @(negedge clk); #1;
  endtask

  task automatic clear_stats();
    n_enq = 0; n_deq = 0; n_both = 0; n_strobe = 0; n_done = 0;
    last_strobe = -1; min_gap = 1000; first_deq = -1; last_enq = -1;
    viol_busy = 0; viol_illegal = 0; viol_occ = 0; viol_ident = 0;
    after_done = 0; after_stop = 0; stop_sent = 1'b0; done_seen = 1'b0;
    qcount = 0;
    kv_log.delete();
  endtask

  task automatic pulse_start(input logic [1:0] m);
    clear_stats();
    mode = m; start = 1'b1;
    step();
    start = 1'b0;
  endtask

  task automatic wait_done(input int budget, output bit ok);
    ok = 1'b0;
    for (int i = 0; i < budget; i++) begin
      step();
      if (n_done > 0) begin ok = 1'b1; break; end
    end
  endtask

  task automatic test_reset();
    rst = 1'b1;
    step(); step();
    checks++; if ({enq, deq} !== 2'b00) begin errors++; $display("FAIL reset_strobes: got %b expected 00", {enq, deq}); end
    checks++; if (kvi !== 16'h0000) begin errors++; $display("FAIL reset_kvi: got %h expected 0000", kvi); end
    checks++; if ({running, done, err} !== 3'b000) begin errors++; $display("FAIL reset_status: got %b expected 000", {running, done, err}); end
    checks++; if ({occ, enq_count, deq_count} !== 36'd0) begin errors++; $display("FAIL reset_counts: got occ=%0d enq=%0d deq=%0d expected 0", occ, enq_count, deq_count); end
    rst = 1'b0;
    step();
    checks++; if (running !== 1'b0) begin errors++; $display("FAIL reset_idle: got running=%b expected 0", running); end
  endtask

  task automatic test_fill_drain();
    bit ok;
    logic [15:0] exp_kv;
    int bad;
    busy_mode = 1'b0;
    clear_stats();
    mode = 2'b00; start = 1'b1; stop = 1'b1;   // start wins over stop in IDLE
    step();
    start = 1'b0; stop = 1'b0;
    checks++; if ({running, enq} !== 2'b10) begin errors++; $display("FAIL fd_issue_cycle: got running,enq=%b expected 10", {running, enq}); end
    step();
    checks++; if (enq !== 1'b1 || kvi !== 16'hACE1) begin errors++; $display("FAIL fd_first_strobe: got enq=%b kvi=%h expected 1 ace1", enq, kvi); end
    wait_done(200, ok);
    checks++; if (!ok) begin errors++; $display("FAIL fd_done_timeout: got no done expected done"); end
    checks++; if (n_enq != 8 || n_deq != 8 || n_both != 0) begin errors++; $display("FAIL fd_op_counts: got enq=%0d deq=%0d both=%0d expected 8 8 0", n_enq, n_deq, n_both); end
    checks++; if (last_enq != 7 || first_deq != 8) begin errors++; $display("FAIL fd_order: got last_enq=%0d first_deq=%0d expected 7 8", last_enq, first_deq); end
    checks++; if (kv_log.size() < 3 || kv_log[1] !== 16'h59C3 || kv_log[2] !== 16'hB387) begin errors++; $display("FAIL fd_kvi_hand: got size=%0d expected 59c3,b387 at 1,2", kv_log.size()); end
    exp_kv = 16'hACE1; bad = 0;
    for (int i = 0; i < 8; i++) begin
      if (i >= kv_log.size() || kv_log[i] !== exp_kv) bad++;
      exp_kv = lfsr_step(exp_kv);
    end
    checks++; if (bad != 0) begin errors++; $display("FAIL fd_kvi_seq: got %0d wrong words expected 0", bad); end
    checks++; if (min_gap != 3) begin errors++; $display("FAIL fd_spacing: got %0d expected 3", min_gap); end
    checks++; if (enq_count !== 16'd8 || deq_count !== 16'd8) begin errors++; $display("FAIL fd_counters: got %0d %0d expected 8 8", enq_count, deq_count); end
    checks++; if (occ !== 4'd0 || err !== 1'b0) begin errors++; $display("FAIL fd_final: got occ=%0d err=%b expected 0 0", occ, err); end
    checks++; if (done !== 1'b1 || running !== 1'b0) begin errors++; $display("FAIL fd_done_idle: got done=%b running=%b expected 1 0", done, running); end
    step();
    checks++; if (done !== 1'b0 || n_done != 1) begin errors++; $display("FAIL fd_done_pulse: got done=%b pulses=%0d expected 0 1", done, n_done); end
    checks++; if (viol_illegal != 0) begin errors++; $display("FAIL fd_legal: got %0d illegal ops expected 0", viol_illegal); end
  endtask

  task automatic test_busy();
    bit ok;
    logic [15:0] exp_kv;
    int bad;
    busy_mode = 1'b1;
    pulse_start(2'b00);
    wait_done(400, ok);
    busy_mode = 1'b0;
    checks++; if (!ok) begin errors++; $display("FAIL busy_done_timeout: got no done expected done"); end
    checks++; if (n_enq != 8 || n_deq != 8) begin errors++; $display("FAIL busy_op_counts: got %0d %0d expected 8 8", n_enq, n_deq); end
    checks++; if (min_gap != 7) begin errors++; $display("FAIL busy_spacing: got %0d expected 7", min_gap); end
    checks++; if (viol_busy != 0) begin errors++; $display("FAIL busy_strobe_while_busy: got %0d expected 0", viol_busy); end
    exp_kv = 16'hACE1; bad = 0;
    for (int i = 0; i < 8; i++) begin
      if (i >= kv_log.size() || kv_log[i] !== exp_kv) bad++;
      exp_kv = lfsr_step(exp_kv);
    end
    checks++; if (bad != 0) begin errors++; $display("FAIL busy_kvi_seq: got %0d wrong words expected 0", bad); end
    checks++; if (enq_count !== 16'd8 || deq_count !== 16'd8 || occ !== 4'd0 || err !== 1'b0) begin errors++; $display("FAIL busy_final: got enq=%0d deq=%0d occ=%0d err=%b expected 8 8 0 0", enq_count, deq_count, occ, err); end
  endtask

  task automatic test_mode_other();
    bit ok;
    for (int m = 2; m < 4; m++) begin
      pulse_start(2'(m));
      wait_done(200, ok);
      checks++; if (!ok || n_enq != 8 || n_deq != 8 || n_both != 0) begin errors++; $display("FAIL mode%0d_as_fill: got done=%b enq=%0d deq=%0d both=%0d expected 1 8 8 0", m, ok, n_enq, n_deq, n_both); end
    end
  endtask

  task automatic test_mix();
    bit ok, reached;
    pulse_start(2'b01);
    reached = 1'b0;
    for (int i = 0; i < 3000; i++) begin
      step();
      if (n_strobe >= 200) begin reached = 1'b1; break; end
    end
    checks++; if (!reached) begin errors++; $display("FAIL mix_200_ops: got %0d ops expected 200", n_strobe); end
    stop_sent = 1'b1;
    stop = 1'b1;
    step();
    stop = 1'b0;
    wait_done(10, ok);
    checks++; if (!ok) begin errors++; $display("FAIL mix_stop_done: got no done expected done"); end
    for (int i = 0; i < 10; i++) step();
    checks++; if (after_stop != 0 || after_done != 0) begin errors++; $display("FAIL mix_after_stop: got %0d after stop, %0d after done expected 0 0", after_stop, after_done); end
    checks++; if (n_strobe != 200) begin errors++; $display("FAIL mix_total_ops: got %0d expected 200", n_strobe); end
    checks++; if (viol_occ != 0 || viol_ident != 0) begin errors++; $display("FAIL mix_occ: got range_viol=%0d ident_viol=%0d expected 0 0", viol_occ, viol_ident); end
    checks++; if (viol_illegal != 0) begin errors++; $display("FAIL mix_legal: got %0d illegal ops expected 0", viol_illegal); end
    checks++; if (n_both == 0) begin errors++; $display("FAIL mix_enq_deq: got %0d replace ops expected >0", n_both); end
    checks++; if (enq_count !== 16'(n_enq) || deq_count !== 16'(n_deq)) begin errors++; $display("FAIL mix_counters: got %0d %0d expected %0d %0d", enq_count, deq_count, n_enq, n_deq); end
    checks++; if (int'(occ) != qcount || err !== 1'b0) begin errors++; $display("FAIL mix_final: got occ=%0d err=%b expected %0d 0", occ, err, qcount); end
  endtask

  task automatic test_err();
    bit ok, seen;
    force_full = 1'b1;
    pulse_start(2'b00);
    seen = 1'b0;
    for (int i = 0; i < 100; i++) begin
      if (err === 1'b1) begin seen = 1'b1; break; end
      step();
    end
    checks++; if (!seen) begin errors++; $display("FAIL err_rise: got err=0 expected 1"); end
    checks++; if (enq_count !== 16'd4) begin errors++; $display("FAIL err_when: got enq_count=%0d at rise expected 4", enq_count); end
    wait_done(200, ok);
    force_full = 1'b0;
    checks++; if (!ok || err !== 1'b1) begin errors++; $display("FAIL err_sticky: got done=%b err=%b expected 1 1", ok, err); end
    step(); step();
    checks++; if (err !== 1'b1) begin errors++; $display("FAIL err_hold_idle: got %b expected 1", err); end
    pulse_start(2'b00);
    checks++; if (err !== 1'b0) begin errors++; $display("FAIL err_clear_start: got %b expected 0", err); end
    wait_done(200, ok);
    checks++; if (!ok || err !== 1'b0) begin errors++; $display("FAIL err_clean_run: got done=%b err=%b expected 1 0", ok, err); end
  endtask

  task automatic test_start_ignored();
    bit ok, reached;
    logic [15:0] exp_kv;
    int bad;
    pulse_start(2'b00);
    reached = 1'b0;
    for (int i = 0; i < 100; i++) begin
      step();
      if (n_enq >= 3) begin reached = 1'b1; break; end
    end
    checks++; if (!reached) begin errors++; $display("FAIL ign_reach: got %0d enq expected 3", n_enq); end
    mode = 2'b01; start = 1'b1;
    step();
    start = 1'b0; mode = 2'b00;
    checks++; if (running !== 1'b1 || enq_count !== 16'd3) begin errors++; $display("FAIL ign_no_restart: got running=%b enq_count=%0d expected 1 3", running, enq_count); end
    wait_done(200, ok);
    checks++; if (!ok || n_enq != 8 || n_deq != 8 || enq_count !== 16'd8 || deq_count !== 16'd8) begin errors++; $display("FAIL ign_counts: got done=%b enq=%0d deq=%0d expected 1 8 8", ok, enq_count, deq_count); end
    exp_kv = 16'hACE1; bad = 0;
    for (int i = 0; i < 8; i++) begin
      if (i >= kv_log.size() || kv_log[i] !== exp_kv) bad++;
      exp_kv = lfsr_step(exp_kv);
    end
    checks++; if (bad != 0) begin errors++; $display("FAIL ign_kvi_seq: got %0d wrong words expected 0", bad); end
  endtask

  task automatic test_rst_mid();
    bit ok, reached;
    pulse_start(2'b00);
    reached = 1'b0;
    for (int i = 0; i < 100; i++) begin
      step();
      if (n_enq >= 2) begin reached = 1'b1; break; end
    end
    checks++; if (!reached || enq !== 1'b1) begin errors++; $display("FAIL rst_pre_hold: got enq=%b expected 1", enq); end
    rst = 1'b1;
    #1;
    checks++; if (enq !== 1'b0 || running !== 1'b0) begin errors++; $display("FAIL rst_async_drop: got enq=%b running=%b expected 0 0", enq, running); end
    checks++; if (enq_count !== 16'd0 || deq_count !== 16'd0 || occ !== 4'd0 || kvi !== 16'd0) begin errors++; $display("FAIL rst_async_clear: got enq=%0d deq=%0d occ=%0d kvi=%h expected 0", enq_count, deq_count, occ, kvi); end
    qcount = 0; busy_left = 0;
    step();
    rst = 1'b0;
    step(); step();
    checks++; if (running !== 1'b0 || enq !== 1'b0) begin errors++; $display("FAIL rst_stays_idle: got running=%b enq=%b expected 0 0", running, enq); end
    pulse_start(2'b00);
    wait_done(200, ok);
    checks++; if (!ok || enq_count !== 16'd8 || deq_count !== 16'd8) begin errors++; $display("FAIL rst_rerun: got done=%b enq=%0d deq=%0d expected 1 8 8", ok, enq_count, deq_count); end
  endtask

  initial begin
    clear_stats();
    test_reset();
    test_fill_drain();
    test_busy();
    test_mode_other();
    test_mix();
    test_err();
    test_start_ignored();
    test_rst_mid();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/pq_traffic_gen.md
# pq_traffic_gen

Self-running stimulus generator that sits directly upstream of the priority queue interface: it drives `enq`, `deq` and `kvi` into the queue and watches its `busy`, `full` and `empty` flags. It replaces the push-button front end for soak testing on the board. It produces pseudo-random 16-bit key/value words from an LFSR and issues operations only when the queue can legally accept them. It keeps its own occupancy count and flags any mismatch with the queue's status outputs.

## Interface
- `CAPACITY`, default 8: queue depth the generator expects; the `full` check compares against this value.
- `SEED`, default 16'hACE1: LFSR load value at reset and on `start`; must be nonzero.
- `clk` input 1: the single clock; all state changes on the rising edge.
- `rst` input 1: asynchronous, active-high reset.
- `start` input 1: single-cycle pulse; begins a run. Accepted only in IDLE.
- `stop` input 1: single-cycle pulse; ends a MIX run after the operation in flight completes.
- `mode` input 2: sampled on `start`.
  - 2'b00: FILL-then-DRAIN.
  - 2'b01: MIX.
  - Other values: treated as 2'b00.
- `busy`, `full`, `empty` inputs 1 each: status flags from the queue.
- `enq`, `deq` outputs 1 each: registered single-cycle operation strobes to the queue. Both high together means enq_deq (replace).
- `kvi` output 16: registered key/value word, valid while `enq` is high.
- `running` output 1: high in every state except IDLE.
- `done` output 1: single-cycle pulse on the return to IDLE.
- `occ` output $clog2(CAPACITY+1): internal occupancy count.
- `enq_count`, `deq_count` outputs 16 each: issued-operation counters; they wrap modulo 2^16.
- `err` output 1: sticky status-mismatch flag.

## Operation
- States: IDLE, ISSUE, HOLD, WAIT.
- Reset values: state = IDLE; `lfsr` = SEED; all outputs 0. `kvi` resets to 0, not SEED.
- LFSR: 16-bit Fibonacci with taps 16, 14, 13, 11. The feedback bit = l[15]^l[13]^l[12]^l[10] shifts into bit 0. It advances by one step only on the edge where an operation is issued.
- IDLE + `start`:
  - Reload `lfsr` = SEED.
  - Clear `occ`, both counters and `err`.
  - Latch `mode` and go to ISSUE.
- ISSUE, evaluated only when `busy`=0; otherwise stay in ISSUE.
  - FILL phase: if `occ` < CAPACITY, issue enq. Otherwise switch to the DRAIN phase, with no operation on that edge.
  - DRAIN phase: if `occ` > 0, issue deq. Otherwise go to IDLE and pulse `done`.
  - MIX mode: the choice is decoded from `lfsr[1:0]`.
    - 00 or 01: enq, downgraded to deq if `occ`=CAPACITY.
    - 10: deq, upgraded to enq if `occ`=0.
    - 11: enq_deq if 0<`occ`<CAPACITY; otherwise enq when empty, deq when full.
  - MIX with a pending stop: go to IDLE with `done` instead of issuing.
- Issuing an operation on an ISSUE edge:
  - Register the strobe(s).
  - Set `kvi` = current `lfsr` if enq is part of the operation.
  - Advance the LFSR and go to HOLD.
- HOLD: lasts one cycle. The strobes are high during this cycle and clear on the edge that leaves it, which always goes to WAIT.
- WAIT: go to ISSUE when `busy`=0.
- Occupancy and counters, updated on the issue edge:
  - enq only: `occ`+1.
  - deq only: `occ`−1.
  - enq_deq: `occ` unchanged.
  - `enq_count` increments for enq and enq_deq; `deq_count` increments for deq and enq_deq.
- Stop: a `stop` pulse in any non-IDLE state sets a pending flag. It is honoured at the next ISSUE evaluation in either mode. The flag clears on IDLE.
- Error check: in ISSUE with `busy`=0, set `err` if `full` != (`occ`==CAPACITY) or `empty` != (`occ`==0). `err` stays set until reset or the next `start`.
- Reset mid-run: the asynchronous reset returns everything to reset values immediately; strobes drop within the same cycle.

## Timing
- `start` edge → ISSUE. The first strobe is high in the following cycle (1 cycle latency) if `busy`=0.
- Minimum spacing between strobe cycles is 3 clocks (ISSUE, HOLD, WAIT), or longer while `busy` is high.
- Strobes are never high for more than one cycle.
- The generator never issues enq while `occ`=CAPACITY and never issues deq while `occ`=0.
- `done` is high for exactly one cycle, coincident with the first IDLE cycle.
- `start` while `running`=1 is ignored.
- `start` and `stop` in the same IDLE cycle: `start` wins and `stop` is ignored.

## Test plan
- Reset, then `start` with `mode`=00 against a queue model with `busy` tied 0 and CAPACITY=8:
  - 8 enq strobes with `kvi` = 16'hACE1 followed by the next 7 LFSR values.
  - Then 8 deq strobes.
  - Then `done`, with `enq_count`=8, `deq_count`=8, `occ`=0 and `err`=0.
- Hold `busy`=1 for 5 cycles after each strobe:
  - No strobe is issued while `busy` is high.
  - Strobe spacing is 7 cycles.
  - Results are otherwise identical to the first scenario.
- MIX run of 200 operations, then `stop`:
  - `occ` stays within 0..8 throughout.
  - `occ` = `enq_count` − `deq_count`.
  - `done` occurs after the operation in flight completes.
  - No strobe is issued after `done`.
- Queue model forces `full`=1 while `occ`=3: `err` rises at the next ISSUE check and stays set until the next `start`.
- Assert `rst` during HOLD with `enq`=1: `enq`, `running` and the counters are 0 in the same cycle, and the state is IDLE.
- Pulse `start` during a run: no effect, and the counters continue from their current values.
